jtlabrun_gfx_romslot: RTL
=========================

// Module: jtlabrun_gfx_romslot
// PURPOSE
//  SDRAM-side responder for the video graphics ROM port (gfx_addr/gfx_romcs -> gfx_data/gfx_ok).
//  Holds recently fetched words in a small cache and fetches misses from the SDRAM arbiter.
//  Returns each word with gfx_ok, qualified against the address currently requested.
//  Sits between jtlabrun_video and the SDRAM controller slot mux.
// PARAMETERS
//  AW      17        requester word-address width
//  DW      16        data width
//  SDRAMW  22        SDRAM word-address width
//  OFFSET  22'h0     base word address of the gfx region in SDRAM (added to gfx_addr)
// PORTS
//  clk          in   1       single system clock (48 MHz)
//  rstn         in   1       synchronous reset, active low
//  gfx_romcs    in   1       request strobe from the video block
//  gfx_addr     in   AW      word address requested
//  gfx_data     out  DW      returned word
//  gfx_ok       out  1       gfx_data is valid for the current gfx_addr
//  sdram_req    out  1       fetch request to the arbiter
//  sdram_addr   out  SDRAMW  fetch address = OFFSET + gfx_addr (zero-extended)
//  sdram_ack    in   1       arbiter accepted the request (1-cycle pulse)
//  sdram_rdy    in   1       sdram_din valid (1-cycle pulse)
//  sdram_din    in   DW      SDRAM read data
// BEHAVIOUR
//  - Reset (rstn=0 at a clk edge): gfx_ok=0, gfx_data=0, sdram_req=0, sdram_addr=0, FSM=IDLE, all cache entries invalid.
//  - FSM states IDLE, REQ, WAIT.
//    IDLE: gfx_romcs=1 and hit -> data registered, ok_r=1 on the next cycle (latency 1).
//          gfx_romcs=1 and miss -> latch gfx_addr as pend_addr, sdram_req=1, go to REQ.
//    REQ:  hold sdram_req and sdram_addr stable until sdram_ack. On ack: drop req, go to WAIT.
//    WAIT: on sdram_rdy, write {pend_addr, sdram_din} into the cache and return to IDLE.
//          If gfx_addr==pend_addr and gfx_romcs=1 in that cycle: gfx_data<=sdram_din and ok_r=1 next cycle.
//  - gfx_ok = ok_r & gfx_romcs & (gfx_addr == addr of the word in gfx_data).
//    This gating is combinational. ok never asserts for a stale address.
//  - Address change mid-fetch: the fetch completes and is cached; ok stays low.
//    The new address is looked up in IDLE on the next cycle.
//  - gfx_romcs drop in REQ: the request stays held until ack (no abort). In WAIT the fetch still completes.
//  - sdram_ack and sdram_rdy in the same cycle while in REQ: treated as ack followed immediately by rdy.
//    The data is captured and the FSM returns to IDLE.
//  - sdram_rdy outside WAIT is ignored.
//  - sdram_addr = OFFSET + {0, pend_addr}, computed modulo 2^SDRAMW (wraps silently).
//  - Reset asserted mid-fetch: FSM goes to IDLE and sdram_req drops immediately. A late rdy is ignored.
// CONFIGURATION
//  JTLABRUN_ROMSLOT_DUAL_EN defined: two-entry cache.
//    Hit on either entry. Fills replace the least-recently-hit entry (1-bit LRU), so alternating tile/object fetches both hit.
//  JTLABRUN_ROMSLOT_DUAL_EN undefined: single entry. Every fill overwrites it.
//  External timing is identical in both builds, apart from hit rate.
// STRUCTURE
//  jtlabrun_pkg: FSM state enum (IDLE/REQ/WAIT) and the default OFFSET constant.
//  Sub-module jtlabrun_romslot_cache: tag/valid/data entries, the hit compare and LRU. The parent holds the FSM and SDRAM handshake.
// TESTING
//  1 Reset, then romcs=1 addr=17'h00123
//    -> sdram_req=1 with sdram_addr=OFFSET+'h123. Ack after 3 cycles, rdy+din=16'hBEEF 2 cycles later
//    -> gfx_data=BEEF and gfx_ok=1 one cycle after rdy.
//  2 After test 1, addr 0->'h124 then back to 'h123
//    -> 'h124 misses. The repeat of 'h123 hits with ok 1 cycle later and no sdram_req
//       (DUAL_EN build; the single-entry build refetches).
//  3 Change addr to 'h200 while in WAIT for 'h123
//    -> gfx_ok stays 0 when rdy arrives. A new req for OFFSET+'h200 follows.
//  4 Drop romcs in REQ
//    -> req held until ack, fetch completes, gfx_ok=0. Re-raise romcs on the same addr -> hit, ok next cycle.
//  5 Assert rstn=0 in WAIT, then pulse rdy
//    -> gfx_ok=0 and req=0. The cache is invalid, so the same addr misses afterwards.
//  6 OFFSET=22'h3FFFF0 with addr 'h20 -> sdram_addr=22'h000010 (wrap).

Source files
------------

// File: rtl/jtlabrun_pkg.sv
// Shared types for the jtlabrun graphics ROM slot: fetch FSM states and default SDRAM placement.
package jtlabrun_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } romslot_state_e;

    localparam logic [21:0] GFX_OFFSET_DEFAULT = 22'h0;

endpackage

// File: rtl/jtlabrun_romslot_cache.sv
// Tag/valid/data store for the gfx ROM slot. JTLABRUN_ROMSLOT_DUAL_EN selects two entries with
// 1-bit LRU replacement; otherwise a single entry that every fill overwrites.
module jtlabrun_romslot_cache #(
    parameter int AW = 17,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic [AW-1:0] lookup_addr,
    input  logic          touch,
    output logic          hit,
    output logic [DW-1:0] hit_data,
    input  logic          fill,
    input  logic [AW-1:0] fill_addr,
    input  logic [DW-1:0] fill_data
);

`ifdef JTLABRUN_ROMSLOT_DUAL_EN
    logic [1:0]    valid_q;
    logic [AW-1:0] tag_q [2];
    logic [DW-1:0] data_q [2];
    logic          lru_q;      // index of the entry the next fill replaces
    logic [1:0]    match;

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            match[i] = valid_q[i] && (tag_q[i] == lookup_addr);
        end
        hit      = |match;
        hit_data = match[1] ? data_q[1] : data_q[0];
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            valid_q <= 2'b00;
            lru_q   <= 1'b0;
        end else if (fill) begin
            valid_q[lru_q] <= 1'b1;
            lru_q          <= ~lru_q;
        end else if (touch && hit) begin
            lru_q <= ~match[1];
        end
    end

    // NOTE: only the valid bits are reset; tags and data are don't-care while invalid,
    // so the storage stays free of reset logic.
    always_ff @(posedge clk) begin
        if (fill) begin
            tag_q[lru_q]  <= fill_addr;
            data_q[lru_q] <= fill_data;
        end
    end
`else
    logic          valid_q;
    logic [AW-1:0] tag_q;
    logic [DW-1:0] data_q;
    logic          unused_touch;

    assign unused_touch = touch;
    assign hit          = valid_q && (tag_q == lookup_addr);
    assign hit_data     = data_q;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            valid_q <= 1'b0;
        end else if (fill) begin
            valid_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (fill) begin
            tag_q  <= fill_addr;
            data_q <= fill_data;
        end
    end
`endif

endmodule

// File: rtl/jtlabrun_gfx_romslot.sv
// SDRAM-side responder for the video gfx ROM port: cache lookup, miss fetch FSM, address-qualified ok.
// Build option: JTLABRUN_ROMSLOT_DUAL_EN enables the two-entry cache in jtlabrun_romslot_cache.
module jtlabrun_gfx_romslot
    import jtlabrun_pkg::*;
#(
    parameter int                AW     = 17,
    parameter int                DW     = 16,
    parameter int                SDRAMW = 22,
    parameter logic [SDRAMW-1:0] OFFSET = SDRAMW'(GFX_OFFSET_DEFAULT)
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              gfx_romcs,
    input  logic [AW-1:0]     gfx_addr,
    output logic [DW-1:0]     gfx_data,
    output logic              gfx_ok,
    output logic              sdram_req,
    output logic [SDRAMW-1:0] sdram_addr,
    input  logic              sdram_ack,
    input  logic              sdram_rdy,
    input  logic [DW-1:0]     sdram_din
);

    romslot_state_e    state_q, state_d;
    logic              req_q, req_d;
    logic [SDRAMW-1:0] saddr_q, saddr_d;
    logic [AW-1:0]     pend_q, pend_d;
    logic [DW-1:0]     data_q, data_d;
    logic [AW-1:0]     dtag_q, dtag_d;   // address of the word currently held in data_q
    logic              ok_q, ok_d;

    logic              hit, touch, fill, capture;
    logic [DW-1:0]     hit_data;

    jtlabrun_romslot_cache #(
        .AW(AW),
        .DW(DW)
    ) u_cache (
        .clk        (clk),
        .rstn       (rstn),
        .lookup_addr(gfx_addr),
        .touch      (touch),
        .hit        (hit),
        .hit_data   (hit_data),
        .fill       (fill),
        .fill_addr  (pend_q),
        .fill_data  (sdram_din)
    );

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        saddr_d = saddr_q;
        pend_d  = pend_q;
        data_d  = data_q;
        dtag_d  = dtag_q;
        ok_d    = 1'b0;
        touch   = 1'b0;
        capture = 1'b0;

        case (state_q)
            IDLE: begin
                if (gfx_romcs) begin
                    if (hit) begin
                        touch  = 1'b1;
                        data_d = hit_data;
                        dtag_d = gfx_addr;
                        ok_d   = 1'b1;
                    end else begin
                        pend_d  = gfx_addr;
                        saddr_d = OFFSET + SDRAMW'(gfx_addr);
                        req_d   = 1'b1;
                        state_d = REQ;
                    end
                end
            end
            REQ: begin
                if (sdram_ack) begin
                    req_d   = 1'b0;
                    state_d = WAIT;
                    capture = sdram_rdy;   // ack and rdy together: data arrives straight away
                end
            end
            WAIT:    capture = sdram_rdy;
            default: state_d = IDLE;
        endcase

        fill = capture;
        if (capture) begin
            state_d = IDLE;
            if (gfx_romcs && (gfx_addr == pend_q)) begin
                data_d = sdram_din;
                dtag_d = pend_q;
                ok_d   = 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            saddr_q <= '0;
            pend_q  <= '0;
            data_q  <= '0;
            dtag_q  <= '0;
            ok_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            saddr_q <= saddr_d;
            pend_q  <= pend_d;
            data_q  <= data_d;
            dtag_q  <= dtag_d;
            ok_q    <= ok_d;
        end
    end

    // ok is re-qualified every cycle so a stale word is never flagged for a new address.
    assign gfx_ok     = ok_q & gfx_romcs & (gfx_addr == dtag_q);
    assign gfx_data   = data_q;
    assign sdram_req  = req_q;
    assign sdram_addr = saddr_q;

endmodule
